// File: rtl/hkspi_passthru_ctrl_if.sv
// Housekeeping SPI / flash pass-thru pin bundle for hkspi_passthru_ctrl.
// HKSPI_USER_PASSTHRU_EN adds the user-flash pin group.
`timescale 1ns/1ps
interface hkspi_passthru_ctrl_if;
  logic       hk_sck;
  logic       hk_csb;
  logic       hk_sdi;
  logic       sdo;
  logic       sdo_oe;
  logic       pt_flash_csb;
  logic       pt_flash_clk;
  logic       pt_flash_io0;
  logic       flash_io1;
  logic       pt_sel;
  logic       pt_cpu_reset;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic [7:0] pt_byte_count;
`ifdef HKSPI_USER_PASSTHRU_EN
  logic       user_flash_csb;
  logic       user_flash_clk;
  logic       user_flash_io0;
  logic       user_flash_io1;
`endif

  modport slave (
    input  hk_sck, hk_csb, hk_sdi, flash_io1,
`ifdef HKSPI_USER_PASSTHRU_EN
    input  user_flash_io1,
    output user_flash_csb, user_flash_clk, user_flash_io0,
`endif
    output sdo, sdo_oe, pt_flash_csb, pt_flash_clk, pt_flash_io0,
    output pt_sel, pt_cpu_reset, cmd_valid, cmd_byte, pt_byte_count
  );

  modport master (
    output hk_sck, hk_csb, hk_sdi, flash_io1,
`ifdef HKSPI_USER_PASSTHRU_EN
    output user_flash_io1,
    input  user_flash_csb, user_flash_clk, user_flash_io0,
`endif
    input  sdo, sdo_oe, pt_flash_csb, pt_flash_clk, pt_flash_io0,
    input  pt_sel, pt_cpu_reset, cmd_valid, cmd_byte, pt_byte_count
  );
endinterface

// File: rtl/hkspi_passthru_ctrl.sv
// Housekeeping SPI command decoder with management-flash pass-thru (command 0xC4).
// Optional HKSPI_USER_PASSTHRU_EN: command 0xC2 passes through to the user-flash pins.
`timescale 1ns/1ps
module hkspi_passthru_ctrl (
  input  logic                  clock,
  input  logic                  reset,
  hkspi_passthru_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CMD, PASS, IGNORE} state_t;

  state_t     state;
  logic       sck_m, sck_s, sck_d;
  logic       csb_m, csb_s;
  logic       sdi_m, sdi_s;
  logic       sck_rise;
  logic [1:0] fill;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] rx_byte;
  logic       clk_ok;
  logic       fwd_csb, fwd_clk, fwd_io0;
  logic       pt_sel, pt_cpu_reset, cmd_valid;
  logic [7:0] cmd_byte, pt_byte_count;
  logic       user_sel;
  logic       ret_io1;
  logic       in_pass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_m <= 1'b0; sck_s <= 1'b0; sck_d <= 1'b0;
      csb_m <= 1'b1; csb_s <= 1'b1;
      sdi_m <= 1'b0; sdi_s <= 1'b0;
    end else begin
      sck_m <= bus.hk_sck; sck_s <= sck_m; sck_d <= sck_s;
      csb_m <= bus.hk_csb; csb_s <= csb_m;
      sdi_m <= bus.hk_sdi; sdi_s <= sdi_m;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign rx_byte  = {shreg, sdi_s};

  // fill/armed: CSB only counts as seen high once the synchroniser holds real pin samples,
  // not its reset preset, so a transaction cut by reset cannot resume.
  // clk_ok blocks the command byte's still-high SCK from appearing as a forwarded edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      fill          <= '0;
      armed         <= 1'b0;
      bit_cnt       <= '0;
      shreg         <= '0;
      clk_ok        <= 1'b0;
      fwd_csb       <= 1'b1;
      fwd_clk       <= 1'b0;
      fwd_io0       <= 1'b0;
      pt_sel        <= 1'b0;
      pt_cpu_reset  <= 1'b0;
      cmd_valid     <= 1'b0;
      cmd_byte      <= '0;
      pt_byte_count <= '0;
`ifdef HKSPI_USER_PASSTHRU_EN
      user_sel      <= 1'b0;
`endif
    end else begin
      cmd_valid <= 1'b0;
      if (fill != 2'd2) fill <= fill + 2'd1;
      else if (csb_s)   armed <= 1'b1;

      if (csb_s) begin
        state        <= IDLE;
        fwd_csb      <= 1'b1;
        fwd_clk      <= 1'b0;
        fwd_io0      <= 1'b0;
        pt_sel       <= 1'b0;
        pt_cpu_reset <= 1'b0;
`ifdef HKSPI_USER_PASSTHRU_EN
        user_sel     <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: if (armed) begin
            state         <= CMD;
            bit_cnt       <= '0;
            pt_byte_count <= '0;
          end
          CMD: if (sck_rise) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte == 8'hC4) begin
                state        <= PASS;
                clk_ok       <= 1'b0;
                fwd_csb      <= 1'b0;
                pt_sel       <= 1'b1;
                pt_cpu_reset <= 1'b1;
              end
`ifdef HKSPI_USER_PASSTHRU_EN
              else if (rx_byte == 8'hC2) begin
                state    <= PASS;
                clk_ok   <= 1'b0;
                fwd_csb  <= 1'b0;
                user_sel <= 1'b1;
              end
`endif
              else begin
                state     <= IGNORE;
                cmd_valid <= 1'b1;
                cmd_byte  <= rx_byte;
              end
            end
          end
          PASS: begin
            if (!sck_s) clk_ok <= 1'b1;
            fwd_clk <= sck_s & clk_ok;
            fwd_io0 <= sdi_s;
            if (sck_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && pt_byte_count != 8'hFF)
                pt_byte_count <= pt_byte_count + 8'd1;
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef HKSPI_USER_PASSTHRU_EN
  assign ret_io1            = user_sel ? bus.user_flash_io1 : bus.flash_io1;
  assign bus.user_flash_csb = user_sel ? fwd_csb : 1'b1;
  assign bus.user_flash_clk = user_sel & fwd_clk;
  assign bus.user_flash_io0 = user_sel & fwd_io0;
`else
  assign user_sel = 1'b0;
  assign ret_io1  = bus.flash_io1;
`endif

  assign in_pass           = (state == PASS);
  assign bus.sdo           = in_pass & ret_io1;
  assign bus.sdo_oe        = in_pass;
  assign bus.pt_flash_csb  = user_sel | fwd_csb;
  assign bus.pt_flash_clk  = ~user_sel & fwd_clk;
  assign bus.pt_flash_io0  = ~user_sel & fwd_io0;
  assign bus.pt_sel        = pt_sel;
  assign bus.pt_cpu_reset  = pt_cpu_reset;
  assign bus.cmd_valid     = cmd_valid;
  assign bus.cmd_byte      = cmd_byte;
  assign bus.pt_byte_count = pt_byte_count;
endmodule

// File: tb/tb_hkspi_passthru_ctrl.sv
// Directed bench for hkspi_passthru_ctrl: SPI host driver, small read-only flash model,
// edge/pulse monitors and hand-computed expectations.
`timescale 1ns/1ps
module tb_hkspi_passthru_ctrl;
  localparam int HP = 6;  // SCK half-period in system clocks

  logic clock = 1'b0;
  logic reset;
  logic io1_force;
  logic [7:0] rx;
  logic [7:0] hdr [4] = '{8'h03, 8'h00, 8'h00, 8'h00};

  always #5 clock = ~clock;

  hkspi_passthru_ctrl_if bus();
  hkspi_passthru_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  // flash model source selection
  logic f_csb, f_clk, f_io0;
  logic fm_io1 = 1'b0;
`ifdef HKSPI_USER_PASSTHRU_EN
  logic fm_user;
  assign f_csb = fm_user ? bus.user_flash_csb : bus.pt_flash_csb;
  assign f_clk = fm_user ? bus.user_flash_clk : bus.pt_flash_clk;
  assign f_io0 = fm_user ? bus.user_flash_io0 : bus.pt_flash_io0;
  assign bus.flash_io1      = (~fm_user & fm_io1) | io1_force;
  assign bus.user_flash_io1 = fm_user & fm_io1;
`else
  assign f_csb = bus.pt_flash_csb;
  assign f_clk = bus.pt_flash_clk;
  assign f_io0 = bus.pt_flash_io0;
  assign bus.flash_io1 = fm_io1 | io1_force;
`endif

  // read-only flash: command 03 at address 0 returns fm_data, shifted out on falling edges
  logic [31:0] fm_hdr = '0;
  int          fm_bits = 0;
  logic        fm_clk_d = 1'b0;
  logic [7:0]  fm_data = 8'h6F;
  always @(negedge clock) begin
    fm_clk_d <= f_clk;
    if (f_csb) begin
      fm_bits <= 0;
      fm_io1  <= 1'b0;
    end else if (f_clk && !fm_clk_d) begin
      if (fm_bits < 32) fm_hdr <= {fm_hdr[30:0], f_io0};
      fm_bits <= fm_bits + 1;
    end else if (!f_clk && fm_clk_d && fm_bits >= 32 && fm_hdr == 32'h0300_0000) begin
      fm_io1 <= fm_data[7 - ((fm_bits - 32) % 8)];
    end
  end

  // monitors
  int   cv_cycles = 0, fclk_rises = 0, flash_act = 0, cpu_drop = 0;
  logic [7:0] cv_byte = '0;
  logic fclk_d = 1'b0;
  always @(negedge clock) begin
    fclk_d <= bus.pt_flash_clk;
    if (bus.cmd_valid) begin
      cv_cycles <= cv_cycles + 1;
      cv_byte   <= bus.cmd_byte;
    end
    if (bus.pt_flash_clk && !fclk_d) fclk_rises <= fclk_rises + 1;
    if (!bus.pt_flash_csb || bus.pt_flash_clk) flash_act <= flash_act + 1;
    if (!bus.pt_flash_csb && !bus.pt_cpu_reset) cpu_drop <= cpu_drop + 1;
  end
`ifdef HKSPI_USER_PASSTHRU_EN
  int   ucl_rises = 0, psel_cyc = 0;
  logic ucl_d = 1'b0;
  always @(negedge clock) begin
    ucl_d <= bus.user_flash_clk;
    if (bus.user_flash_clk && !ucl_d) ucl_rises <= ucl_rises + 1;
    if (bus.pt_sel) psel_cyc <= psel_cyc + 1;
  end
`endif

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      bus.hk_sdi = tx[i];
      wait_clk(HP);
      r[i] = bus.sdo;
      bus.hk_sck = 1'b1;
      wait_clk(HP);
      bus.hk_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
    spi_bits(tx, 8, r);
  endtask

  task automatic cs_low();
    bus.hk_csb = 1'b0;
    wait_clk(HP);
  endtask

  task automatic cs_high();
    wait_clk(HP);
    bus.hk_csb = 1'b1;
    wait_clk(2 * HP);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s_cv, s_fr, s_act, s_drop;
    reset = 1'b1; io1_force = 1'b0;
    bus.hk_sck = 1'b0; bus.hk_csb = 1'b1; bus.hk_sdi = 1'b0;
`ifdef HKSPI_USER_PASSTHRU_EN
    fm_user = 1'b0;
`endif
    wait_clk(3);
    check("rst_flash_csb", bus.pt_flash_csb, 1);
    check("rst_flash_clk", bus.pt_flash_clk, 0);
    check("rst_flash_io0", bus.pt_flash_io0, 0);
    check("rst_pt_sel", bus.pt_sel, 0);
    check("rst_cpu_reset", bus.pt_cpu_reset, 0);
    check("rst_sdo_oe", {bus.sdo, bus.sdo_oe}, 0);
    check("rst_cmd_valid", bus.cmd_valid, 0);
    check("rst_cmd_byte", bus.cmd_byte, 8'h00);
    check("rst_count", bus.pt_byte_count, 0);
    reset = 1'b0;
    wait_clk(4);

    // mgmt flash read through pass-thru
    s_fr = fclk_rises; s_drop = cpu_drop; s_cv = cv_cycles;
    cs_low();
    spi_byte(8'hC4, rx);
    check("pass_sel", bus.pt_sel, 1);
    check("pass_oe", bus.sdo_oe, 1);
    for (int i = 0; i < 4; i++) begin
      spi_byte(hdr[i], rx);
      check("pass_cpu_reset", bus.pt_cpu_reset, 1);
    end
    spi_byte(8'h00, rx);
    check("read_data", rx, 8'h6F);
    wait_clk(HP);
    bus.hk_csb = 1'b1;
    check("pass_count", bus.pt_byte_count, 5);
    wait_clk(4);
    check("release_csb", bus.pt_flash_csb, 1);
    check("pass_fclk_rises", fclk_rises - s_fr, 40);
    check("pass_cpu_drop", cpu_drop - s_drop, 0);
    check("pass_no_cmd", cv_cycles - s_cv, 0);
    wait_clk(2 * HP);

    // ordinary command: one strobe, flash untouched, SDO quiet
    s_cv = cv_cycles; s_act = flash_act;
    io1_force = 1'b1;
    cs_low();
    spi_byte(8'h80, rx);
    check("ign_sdo", {bus.sdo, bus.sdo_oe}, 0);
    spi_byte(8'h0B, rx);
    spi_byte(8'h01, rx);
    cs_high();
    io1_force = 1'b0;
    check("cmd_pulses", cv_cycles - s_cv, 1);
    check("cmd_strobe_byte", cv_byte, 8'h80);
    check("cmd_byte_hold", bus.cmd_byte, 8'h80);
    check("cmd_flash_idle", flash_act - s_act, 0);

    // aborted partial byte, then pass-thru
    s_cv = cv_cycles;
    cs_low();
    spi_bits(8'hC4, 4, rx);
    cs_high();
    check("abort_no_cmd", cv_cycles - s_cv, 0);
    cs_low();
    spi_byte(8'hC4, rx);
    s_fr = fclk_rises;
    spi_byte(8'h9F, rx);
    check("abort_pass_sel", bus.pt_sel, 1);
    check("abort_fclk_rises", fclk_rises - s_fr, 8);
    cs_high();
    check("abort_count", bus.pt_byte_count, 1);
    check("abort_no_cmd2", cv_cycles - s_cv, 0);

    // reset mid-PASS, then CSB must rise before a new transaction
    cs_low();
    spi_byte(8'hC4, rx);
    spi_byte(8'h03, rx);
    spi_bits(8'h00, 3, rx);
    check("mid_pass_sel", bus.pt_sel, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_csb", bus.pt_flash_csb, 1);
    check("mid_rst_clk", bus.pt_flash_clk, 0);
    check("mid_rst_sel", {bus.pt_sel, bus.pt_cpu_reset}, 0);
    check("mid_rst_sdo", {bus.sdo, bus.sdo_oe}, 0);
    check("mid_rst_count", bus.pt_byte_count, 0);
    wait_clk(2);
    reset = 1'b0;
    s_cv = cv_cycles;
    spi_byte(8'h55, rx);
    check("post_rst_blocked", cv_cycles - s_cv, 0);
    check("post_rst_sel", bus.pt_sel, 0);
    cs_high();
    cs_low();
    spi_byte(8'h55, rx);
    cs_high();
    check("post_rst_accept", cv_cycles - s_cv, 1);
    check("post_rst_byte", bus.cmd_byte, 8'h55);

    // byte counter saturation, hold and clear
    cs_low();
    spi_byte(8'hC4, rx);
    for (int i = 0; i < 300; i++) spi_byte(i[7:0], rx);
    check("sat_count", bus.pt_byte_count, 255);
    wait_clk(HP);
    bus.hk_csb = 1'b1;
    wait_clk(4 * HP);
    check("sat_hold", bus.pt_byte_count, 255);
    cs_low();
    check("sat_clear", bus.pt_byte_count, 0);
    cs_high();

    // command 0xC2
`ifdef HKSPI_USER_PASSTHRU_EN
    begin
      int s_ucl, s_ps;
      fm_user = 1'b1;
      s_ucl = ucl_rises; s_ps = psel_cyc; s_act = flash_act; s_cv = cv_cycles;
      cs_low();
      spi_byte(8'hC2, rx);
      check("user_oe", bus.sdo_oe, 1);
      for (int i = 0; i < 4; i++) spi_byte(hdr[i], rx);
      check("user_cpu_reset", bus.pt_cpu_reset, 0);
      spi_byte(8'h00, rx);
      check("user_read_data", rx, 8'h6F);
      cs_high();
      check("user_clk_rises", ucl_rises - s_ucl, 40);
      check("user_pt_sel", psel_cyc - s_ps, 0);
      check("user_mgmt_idle", flash_act - s_act, 0);
      check("user_no_cmd", cv_cycles - s_cv, 0);
      check("user_release", bus.user_flash_csb, 1);
      fm_user = 1'b0;
    end
`else
    s_cv = cv_cycles; s_act = flash_act;
    cs_low();
    spi_byte(8'hC2, rx);
    spi_byte(8'h03, rx);
    cs_high();
    check("c2_pulses", cv_cycles - s_cv, 1);
    check("c2_strobe_byte", cv_byte, 8'hC2);
    check("c2_cmd_byte", bus.cmd_byte, 8'hC2);
    check("c2_flash_idle", flash_act - s_act, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
